// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI message parser: parser state encoding,
// status byte constants, message length lookup and the UART divisor helper.
package midi_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no running status
    S_D1   = 2'd1,  // awaiting first data byte
    S_D2   = 2'd2   // awaiting second data byte
  } state_t;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] PROG     = 8'hC0;
  localparam logic [7:0] CHPRES   = 8'hD0;
  localparam logic [7:0] SYS      = 8'hF0;
  localparam logic [7:0] RT       = 8'hF8;

  // Width of a buffered message: status(8) + data1(7) + data2(7).
  localparam int unsigned MSG_W = 22;

  // Number of data bytes following a channel status byte.
  function automatic logic [1:0] data_len(input logic [7:0] status);
    if ((status[7:4] == PROG[7:4]) || (status[7:4] == CHPRES[7:4])) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

  // Receiver divisor for 8x oversampling.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input int unsigned baud);
    return 16'(clk_hz / (baud * 8) - 1);
  endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Bundle between the parser, the UART receiver and the tone-generator scheduler.
//   o_baud      receiver divisor (static)
//   i_rxFlg     one-cycle received-byte strobe, i_rxData the byte
//   i_chMask    per-channel accept mask
//   o_msgValid / i_msgReady  message port handshake
//   o_status / o_data1 / o_data2  head message
//   o_overrun   one-cycle pulse, message dropped on a full buffer
// The master modport is the parser side; slave is its environment.
interface midi_msg_parser_if;
  logic [15:0] o_baud;
  logic        i_rxFlg;
  logic [7:0]  i_rxData;
  logic [15:0] i_chMask;
  logic        o_msgValid;
  logic        i_msgReady;
  logic [7:0]  o_status;
  logic [6:0]  o_data1;
  logic [6:0]  o_data2;
  logic        o_overrun;

  modport master (
    output o_baud, o_msgValid, o_status, o_data1, o_data2, o_overrun,
    input  i_rxFlg, i_rxData, i_chMask, i_msgReady
  );

  modport slave (
    input  o_baud, o_msgValid, o_status, o_data1, o_data2, o_overrun,
    output i_rxFlg, i_rxData, i_chMask, i_msgReady
  );
endinterface

// File: rtl/midi_msg_fifo2.sv
// Two-entry synchronous FIFO for assembled messages.
//   clk, res_n  clock and synchronous active-low reset
//   push/wdata  write request; ignored when full unless popping the same cycle
//   pop         read request; ignored when empty
//   rdata       head entry (zero after reset)
//   count/full  occupancy
module midi_msg_fifo2
  import midi_pkg::*;
(
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic [MSG_W-1:0] wdata,
  input  logic             pop,
  output logic [MSG_W-1:0] rdata,
  output logic [1:0]       count,
  output logic             full
);

  logic [MSG_W-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == 2'd2);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // When full, wr_ptr equals rd_ptr: a simultaneous pop vacates exactly the
  // slot being written, so push+pop on a full FIFO is safe.
  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser with running status and channel filter.
//   i_clk, i_res_n  clock and synchronous active-low reset
//   bus             receiver byte strobe in, channel mask in, buffered
//                   message port out, overrun pulse out, static baud divisor out
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ = 24_000_000,
  parameter int unsigned BAUD   = 31_250
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  midi_msg_parser_if.master  bus
);

  state_t          state_q, state_d;
  logic [7:0]      run_stat_q, run_stat_d;
  logic [6:0]      d1_q, d1_d;
  logic            overrun_q;

  logic            cmpl;
  logic [7:0]      cmpl_status;
  logic [6:0]      cmpl_d1;
  logic [6:0]      cmpl_d2;
  logic [7:0]      msg_status;
  logic            push;
  logic            pop;
  logic            overrun_d;

  logic [MSG_W-1:0] fifo_rdata;
  logic [1:0]       fifo_count;
  logic             fifo_full;

  logic [7:0]       rx_byte;
  assign rx_byte = bus.i_rxData;

  assign bus.o_baud = baud_div(CLK_HZ, BAUD);

  // Parser next-state and message completion.
  always_comb begin
    state_d     = state_q;
    run_stat_d  = run_stat_q;
    d1_d        = d1_q;
    cmpl        = 1'b0;
    cmpl_status = run_stat_q;
    cmpl_d1     = '0;
    cmpl_d2     = '0;

    if (bus.i_rxFlg) begin
      if (rx_byte >= RT) begin
        // Realtime bytes may interleave anywhere and leave parsing untouched.
      end else if (rx_byte >= SYS) begin
        run_stat_d = '0;
        state_d    = S_IDLE;
      end else if (rx_byte[7]) begin
        run_stat_d = rx_byte;
        state_d    = S_D1;
      end else begin
        case (state_q)
          S_D1: begin
            if (data_len(run_stat_q) == 2'd1) begin
              cmpl    = 1'b1;
              cmpl_d1 = rx_byte[6:0];
            end else begin
              d1_d    = rx_byte[6:0];
              state_d = S_D2;
            end
          end
          S_D2: begin
            cmpl    = 1'b1;
            cmpl_d1 = d1_q;
            cmpl_d2 = rx_byte[6:0];
            state_d = S_D1;
          end
          default: begin
            // No running status: stray data is dropped.
          end
        endcase
      end
    end
  end

  // Note-On with zero velocity is delivered as Note-Off.
  always_comb begin
    msg_status = cmpl_status;
    if ((cmpl_status[7:4] == NOTE_ON[7:4]) && (cmpl_d2 == 7'd0)) begin
      msg_status = {NOTE_OFF[7:4], cmpl_status[3:0]};
    end
  end

  assign push      = cmpl & bus.i_chMask[run_stat_q[3:0]];
  assign pop       = bus.o_msgValid & bus.i_msgReady;
  assign overrun_d = push & fifo_full & ~pop;

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q    <= S_IDLE;
      run_stat_q <= '0;
      d1_q       <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_stat_q <= run_stat_d;
      d1_q       <= d1_d;
      overrun_q  <= overrun_d;
    end
  end

  midi_msg_fifo2 u_fifo (
    .clk   (i_clk),
    .res_n (i_res_n),
    .push  (push),
    .wdata ({msg_status, cmpl_d1, cmpl_d2}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign bus.o_msgValid = (fifo_count != 2'd0);
  assign bus.o_status   = fifo_rdata[21:14];
  assign bus.o_data1    = fifo_rdata[13:7];
  assign bus.o_data2    = fifo_rdata[6:0];
  assign bus.o_overrun  = overrun_q;

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-level MIDI controller sitting directly behind the UART receiver in the MIDI sounder. Drives the receiver's baud divisor and consumes its one-cycle byte strobes. Assembles channel-voice messages, including running status, and filters them by channel. Delivers complete messages through a 2-entry buffered valid/ready port to the tone-generator scheduler.

## Interface
Parameters:
- CLK_HZ, 24_000_000, system clock frequency
- BAUD, 31_250, MIDI bit rate

Ports:
- i_clk  in  1  system clock; single clock domain
- i_res_n  in  1  reset; synchronous, active-low
- o_baud  out  16  receiver divisor, constant CLK_HZ/(BAUD*8)-1 (95 at defaults)
- i_rxFlg  in  1  one-cycle strobe, received byte valid
- i_rxData  in  8  received byte, valid with i_rxFlg
- i_chMask  in  16  bit n=1 accepts channel n; sampled at message completion
- o_msgValid  out  1  buffered message available
- i_msgReady  in  1  consumer accepts head message
- o_status  out  8  head status byte
- o_data1  out  7  head first data byte
- o_data2  out  7  head second data byte; 0 for 1-data-byte messages
- o_overrun  out  1  one-cycle pulse, completed message dropped because buffer full

## Operation
- Parser states: S_IDLE (no running status), S_D1 (awaiting first data), S_D2 (awaiting second data). Registers: runStat[7:0], d1[6:0].
- Byte handling applies only on cycles with i_rxFlg=1:
  - 0x80–0xEF (channel status):
    - runStat <= byte; go S_D1 from any state.
    - Any partial message is discarded.
  - 0xF0–0xF7 (system common/SysEx): runStat cleared; go S_IDLE.
  - 0xF8–0xFF (realtime): ignored entirely; state, runStat and d1 unchanged.
  - 0x00–0x7F (data):
    - S_IDLE: drop.
    - S_D1, length-1 status (0xCn, 0xDn): complete with data2=0; stay S_D1.
    - S_D1, length-2 status: d1 <= byte; go S_D2.
    - S_D2: complete; return to S_D1 (running status retained).
- On completion:
  - Note-On with velocity 0 (0x9n, data2=0) is rewritten to status 0x8n, data2=0.
  - If i_chMask[runStat[3:0]]=0, the message is discarded silently.
  - Otherwise the message is pushed to the buffer.
- Buffer: 2-entry FIFO, head on o_status/o_data1/o_data2.
  - o_msgValid = (count != 0).
  - Pop on o_msgValid & i_msgReady.
  - Push when full without a same-cycle pop: message dropped, o_overrun pulses, FIFO contents unchanged.
  - Full with simultaneous push and pop: both performed; no overrun.
  - Empty with push: entry written; pop impossible that cycle.
- Head outputs hold their value while o_msgValid=1 and i_msgReady=0.
- Head outputs are don't-care while o_msgValid=0; they are driven 0 after reset.

## Timing
- Reset (i_res_n=0 at a clock edge):
  - o_msgValid=0, o_status=0, o_data1=0, o_data2=0, o_overrun=0.
  - FIFO count=0; state S_IDLE; runStat=0.
- Reset mid-message discards partial and buffered messages.
- o_baud is static; it does not depend on reset.
- Latency: i_rxFlg on the completing byte in cycle N gives o_msgValid=1 in cycle N+1 (FIFO previously empty).
- o_overrun is asserted in cycle N+1 for a drop decided in cycle N.
- Pop in cycle N: next entry on the head outputs in cycle N+1.
- Sustained throughput: one message per cycle when i_msgReady=1. The receiver's byte rate (≥320 µs/byte) never stresses it.
- i_rxFlg is a single-cycle strobe. The parser does not require gaps; a strobe on every cycle is handled correctly.

## Structure
- Package midi_pkg holds:
  - state encoding (S_IDLE/S_D1/S_D2)
  - status constants: NOTE_OFF=0x80, NOTE_ON=0x90, PROG=0xC0, CHPRES=0xD0, SYS=0xF0, RT=0xF8
  - function data_len(status) returning 1 or 2
  - the o_baud divisor computation
- Sub-module midi_msg_fifo2: 2-deep, 22-bit-wide synchronous FIFO with push/pop/count/full; same clock and reset.
- Parser FSM and completion and filter logic stay in midi_msg_parser.

## Test plan
- Reset, then bytes 0x93 0x3C 0x64 with i_msgReady=1 → one message 0x93/0x3C/0x64; o_msgValid one cycle after the strobe of 0x64.
- Running status: bytes 0x90 0x40 0x50 0x41 0x00 → messages 0x90/0x40/0x50, then 0x80/0x41/0x00.
- Bytes 0xC2 0x05 0xF8 0x07 → 0xC2/0x05/0x00 and 0xC2/0x07/0x00; realtime 0xF8 ignored.
- Bytes 0x91 0x3C, then 0xF0, then 0x40 0x7F, with i_chMask=0xFFFF → no message emitted.
- i_chMask=0x0001, stream 0x91 0x3C 0x40 then 0x90 0x3C 0x40 → only the channel-0 message emitted.
- i_msgReady=0, three complete messages → first two buffered, o_overrun pulses once on the third. Assert ready: two pops in order. Separately, push and pop on a full FIFO in the same cycle → no overrun.
